datapath_mux_unit: RTL and testbench

Groups the three datapath selectors of the single-cycle MIPS core:
- register-file write-address select (RegDst);
- write-back data select (DatatoReg);
- ALU second-operand select (ALUSrc).

All data paths are purely combinational, so they fit in the same cycle as instruction fetch, decode and execute. A small clocked monitor latches sticky error flags when an illegal select code is used while a register write is enabled.

---
 rtl/datapath_mux_unit_pkg.sv | 26 ++
 rtl/datapath_mux_unit_if.sv | 44 ++++
 rtl/datapath_mux_unit_sel_mux4.sv | 21 ++
 rtl/datapath_mux_unit.sv | 56 +++++
 tb/tb_datapath_mux_unit.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/datapath_mux_unit_pkg.sv
// Select encodings shared by the datapath selector slice of the
// single-cycle MIPS core.
package mux_sel_pkg;

    typedef enum logic [1:0] {
        RD_RT   = 2'b00,
        RD_RD   = 2'b01,
        RD_LINK = 2'b10,
        RD_ILL  = 2'b11
    } regdst_e;

    typedef enum logic [1:0] {
        DTR_ALU = 2'b00,
        DTR_MEM = 2'b01,
        DTR_PC4 = 2'b10,
        DTR_ILL = 2'b11
    } dtr_e;

    typedef enum logic {
        SRC_REG = 1'b0,
        SRC_IMM = 1'b1
    } alusrc_e;

    localparam int unsigned LINK_REG_DEF = 31;

endpackage

// File: rtl/datapath_mux_unit_if.sv
// Select inputs, data operands and selected results of the
// datapath selector slice.
interface datapath_mux_unit_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic [1:0]    regdst_sel;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [AW-1:0] reg_rd;

    logic [1:0]    dtr_sel;
    logic [DW-1:0] alu_out;
    logic [DW-1:0] dm_data_out;
    logic [DW-1:0] pc_plus4;
    logic [DW-1:0] data_to_reg;

    logic          alusrc;
    logic [DW-1:0] grf_out_b;
    logic [DW-1:0] ext_out;
    logic [DW-1:0] alusrc_out;

    logic          regwrite;
    logic          err_regdst;
    logic          err_dtr;

    modport master (
        output regdst_sel, rt, rd,
        output dtr_sel, alu_out, dm_data_out, pc_plus4,
        output alusrc, grf_out_b, ext_out,
        output regwrite,
        input  reg_rd, data_to_reg, alusrc_out,
        input  err_regdst, err_dtr
    );

    modport slave (
        input  regdst_sel, rt, rd,
        input  dtr_sel, alu_out, dm_data_out, pc_plus4,
        input  alusrc, grf_out_b, ext_out,
        input  regwrite,
        output reg_rd, data_to_reg, alusrc_out,
        output err_regdst, err_dtr
    );
endinterface

// File: rtl/datapath_mux_unit_sel_mux4.sv
// Width-parameterised 4:1 selector whose fourth leg is a fixed zero.
module sel_mux4 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    output logic [W-1:0] y
);
    // Unknown or illegal selects fall to zero so no X reaches the GRF
    always_comb begin
        y = '0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            default: y = '0;
        endcase
    end
endmodule

// File: rtl/datapath_mux_unit.sv
// RegDst, DatatoReg and ALUSrc selectors plus sticky flags that
// record illegal select codes used during a register write.
module datapath_mux_unit
    import mux_sel_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int LINK_REG = LINK_REG_DEF
) (
    input logic           clk,
    input logic           reset,
    datapath_mux_unit_if.slave bus
);
    localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

    logic err_regdst_q;
    logic err_dtr_q;

    sel_mux4 #(.W(AW)) u_regdst_mux (
        .sel (bus.regdst_sel),
        .d0  (bus.rt),
        .d1  (bus.rd),
        .d2  (LINK_ADDR),
        .y   (bus.reg_rd)
    );

    sel_mux4 #(.W(DW)) u_dtr_mux (
        .sel (bus.dtr_sel),
        .d0  (bus.alu_out),
        .d1  (bus.dm_data_out),
        .d2  (bus.pc_plus4),
        .y   (bus.data_to_reg)
    );

    // Case equality keeps an unknown alusrc from blending both operands
    assign bus.alusrc_out =
        (bus.alusrc === SRC_IMM) ? bus.ext_out   :
        (bus.alusrc === SRC_REG) ? bus.grf_out_b :
                                   '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_regdst_q <= 1'b0;
            err_dtr_q    <= 1'b0;
        end else begin
            if (bus.regwrite && bus.regdst_sel == RD_ILL)
                err_regdst_q <= 1'b1;
            if (bus.regwrite && bus.dtr_sel == DTR_ILL)
                err_dtr_q <= 1'b1;
        end
    end

    assign bus.err_regdst = err_regdst_q;
    assign bus.err_dtr    = err_dtr_q;

endmodule

// File: tb/tb_datapath_mux_unit.sv
// Directed scoreboard bench for datapath_mux_unit.
module tb_datapath_mux_unit;

    logic clk;
    logic reset;

    datapath_mux_unit_if #(.DW(32), .AW(5)) bus ();

    datapath_mux_unit #(
        .DW       (32),
        .AW       (5),
        .LINK_REG (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  rd;
        logic [31:0] dtr;
        logic [31:0] src;
        logic        er;
        logic        ed;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   checks = 0;
    int   errors = 0;

    task automatic cmp(input string n, input string f,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the stimulus presents a sample
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (q.size() != 0) begin
                e = q.pop_front();
                cmp(e.name, "reg_rd", 32'(bus.reg_rd), 32'(e.rd));
                cmp(e.name, "data_to_reg", bus.data_to_reg, e.dtr);
                cmp(e.name, "alusrc_out", bus.alusrc_out, e.src);
                cmp(e.name, "err_regdst", 32'(bus.err_regdst), 32'(e.er));
                cmp(e.name, "err_dtr", 32'(bus.err_dtr), 32'(e.ed));
            end
        end
    end

    task automatic expect_now(input string n, input logic [4:0] rd,
                              input logic [31:0] dtr, input logic [31:0] src,
                              input logic er, input logic ed);
        exp_t e;
        e.name = n;
        e.rd   = rd;
        e.dtr  = dtr;
        e.src  = src;
        e.er   = er;
        e.ed   = ed;
        #1;
        q.push_back(e);
        ->chk_ev;
        for (int i = 0; i < 5 && q.size() != 0; i++) #1;
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s monitor_timeout pending=%0d required=0", n, q.size());
            q.delete();
        end
    endtask

    task automatic drive(input logic [1:0] rs, input logic [1:0] ds,
                         input logic as, input logic rw);
        bus.regdst_sel = rs;
        bus.dtr_sel    = ds;
        bus.alusrc     = as;
        bus.regwrite   = rw;
    endtask

    initial begin
        reset           = 1'b0;
        bus.rt          = 5'd8;
        bus.rd          = 5'd9;
        bus.alu_out     = 32'h0000_1234;
        bus.dm_data_out = 32'hDEAD_BEEF;
        bus.pc_plus4    = 32'h0000_3004;
        bus.grf_out_b   = 32'hFFFF_FFFF;
        bus.ext_out     = 32'hFFFF_8000;
        drive(2'b11, 2'b11, 1'b0, 1'b1);

        // Illegal write across an edge while reset is low is ignored
        @(posedge clk);
        @(negedge clk);
        expect_now("reset_ill", 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        drive(2'b00, 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        expect_now("sel00", 5'd8, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b0);

        @(negedge clk);
        drive(2'b01, 2'b01, 1'b1, 1'b0);
        expect_now("sel01", 5'd9, 32'hDEAD_BEEF, 32'hFFFF_8000, 1'b0, 1'b0);

        drive(2'b10, 2'b10, 1'b1, 1'b0);
        expect_now("sel10", 5'd31, 32'h0000_3004, 32'hFFFF_8000, 1'b0, 1'b0);

        drive(2'b11, 2'b11, 1'b0, 1'b0);
        expect_now("sel11_nowr", 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        expect_now("nowr_edge", 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        drive(2'b11, 2'b00, 1'b0, 1'b1);
        expect_now("rd_ill_pre", 5'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        expect_now("rd_ill_set", 5'd8, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        expect_now("rd_ill_hold", 5'd8, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0);

        drive(2'b11, 2'b11, 1'b0, 1'b1);
        @(negedge clk);
        expect_now("both_set", 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);

        // Mid-cycle async reset clears flags; muxes keep tracking
        #2;
        reset  = 1'b0;
        bus.rt = 5'd3;
        drive(2'b00, 2'b11, 1'b0, 1'b1);
        expect_now("async_clr", 5'd3, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge clk);
        expect_now("rst_hold", 5'd3, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        bus.alu_out     = 32'h0;
        bus.dm_data_out = 32'h0;
        bus.pc_plus4    = 32'h0;
        bus.grf_out_b   = 32'h0;
        bus.ext_out     = 32'h0;
        drive(2'b00, 2'bxx, 1'bx, 1'b0);
        expect_now("x_sel", 5'd3, 32'h0, 32'h0, 1'b0, 1'b0);

        // First edge after release may set a flag
        drive(2'b00, 2'b11, 1'b0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        drive(2'b01, 2'b00, 1'b0, 1'b0);
        expect_now("first_edge", 5'd9, 32'h0, 32'h0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
